decn_reg: RTL and testbench

- Parametrised, registered N-to-M one-hot decoder. Successor to the fixed 3-to-8 combinational decoder.
- Adds valid/ready handshakes on both sides, a one-entry output register, three output modes (level, pulse, sticky-accumulate) and out-of-range code detection.
- Used in npc for register-file write-enable, CSR select and interrupt-line fan-out, where a registered and flow-controlled select is needed.

---
 rtl/decn_pkg.sv | 18 +
 rtl/decn_onehot.sv | 24 ++
 rtl/decn_reg.sv | 110 +++++++++++
 tb/tb_decn_reg.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/decn_pkg.sv
// Shared types for the registered one-hot decoder (decn_reg) and its decode block.
package decn_pkg;

    typedef enum logic [1:0] {
        DECN_LEVEL = 2'd0,
        DECN_PULSE = 2'd1,
        DECN_ACCUM = 2'd2,
        DECN_RSVD  = 2'd3
    } decn_mode_e;

    typedef enum logic {
        DECN_IDLE,
        DECN_FULL
    } decn_state_e;

    localparam int HITCNT_W = 16;

endpackage

// File: rtl/decn_onehot.sv
// Combinational binary-to-one-hot decode with out-of-range flag; codes >= OUT_W never set a bit.
module decn_onehot #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  code,
    input  logic             en,
    output logic [OUT_W-1:0] dec,
    output logic             err
);

    localparam logic [IN_W:0] LIMIT = (IN_W+1)'(OUT_W);

    always_comb begin
        err = ({1'b0, code} >= LIMIT);
        dec = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            if (en && (code == IN_W'(i))) begin
                dec[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decn_reg.sv
// Registered, flow-controlled N-to-M one-hot decoder with LEVEL/PULSE/ACCUM output modes.
// Optional saturating in-range hit counter port hit_cnt when DECN_REG_HITCNT_EN is defined.
module decn_reg
    import decn_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_err
`ifdef DECN_REG_HITCNT_EN
   ,output logic [HITCNT_W-1:0] hit_cnt
`endif
);

    if (OUT_W < 1 || OUT_W > (1 << IN_W)) begin : g_param_check
        $error("decn_reg: OUT_W=%0d is illegal for IN_W=%0d", OUT_W, IN_W);
    end

    decn_state_e      state_q, state_d;
    decn_mode_e       mode_in, mode_q;
    logic [OUT_W-1:0] mask_q;
    logic [OUT_W-1:0] dec;
    logic             dec_err;
    logic             in_hs, out_hs;

    decn_onehot #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_onehot (
        .code (in_code),
        .en   (en),
        .dec  (dec),
        .err  (dec_err)
    );

    assign mode_in  = decn_mode_e'(mode);
    assign in_ready = !rst && (!out_valid || out_ready);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DECN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = DECN_IDLE;
        end else begin
            unique case (state_q)
                DECN_IDLE: if (in_hs) state_d = DECN_FULL;
                DECN_FULL: if (!in_hs && out_ready) state_d = DECN_IDLE;
                default:   state_d = DECN_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q == DECN_FULL);
    end

    // mode_q remembers how the held entry was loaded so a later mode change never re-decodes it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            out_onehot <= '0;
            out_err    <= 1'b0;
            mask_q     <= '0;
            mode_q     <= DECN_LEVEL;
        end else if (in_hs) begin
            out_err <= dec_err;
            mode_q  <= mode_in;
            if (mode_in == DECN_ACCUM) begin
                out_onehot <= mask_q | dec;
                mask_q     <= mask_q | dec;
            end else begin
                out_onehot <= dec;
            end
        end else if (out_hs && mode_q == DECN_PULSE) begin
            out_onehot <= '0;
        end
    end

`ifdef DECN_REG_HITCNT_EN
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hit_cnt <= '0;
        end else if (in_hs && !dec_err && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + HITCNT_W'(1);
        end
    end
`else
    // Hit counting is compiled out: no counter state in this build.
`endif

endmodule

// File: tb/tb_decn_reg.sv
// Directed, table-driven bench for decn_reg; two instances share stimulus (OUT_W=8 and OUT_W=6).
module tb_decn_reg;

    logic       clk = 1'b0;
    logic       rst, en, clr, in_valid, out_ready;
    logic [1:0] mode;
    logic [2:0] in_code;

    logic       in_ready8, out_valid8, out_err8;
    logic [7:0] out_onehot8;
    logic       in_ready6, out_valid6, out_err6;
    logic [5:0] out_onehot6;
`ifdef DECN_REG_HITCNT_EN
    logic [15:0] hit_cnt8, hit_cnt6;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decn_reg #(.IN_W(3), .OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .mode(mode), .en(en), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready8), .in_code(in_code),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_onehot(out_onehot8), .out_err(out_err8)
`ifdef DECN_REG_HITCNT_EN
       ,.hit_cnt(hit_cnt8)
`endif
    );

    decn_reg #(.IN_W(3), .OUT_W(6)) dut6 (
        .clk(clk), .rst(rst), .mode(mode), .en(en), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready6), .in_code(in_code),
        .out_valid(out_valid6), .out_ready(out_ready),
        .out_onehot(out_onehot6), .out_err(out_err6)
`ifdef DECN_REG_HITCNT_EN
       ,.hit_cnt(hit_cnt6)
`endif
    );

    typedef struct {
        logic       rst, en, clr, vld, rdy;
        logic [1:0] mode;
        logic [2:0] code;
        bit         w6;
        logic       x_ir, x_ov;
        logic [7:0] x_oh;
        logic       x_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic c, input logic v,
                       input logic rd, input logic [1:0] m, input logic [2:0] cd, input bit w6,
                       input logic ir, input logic ov, input logic [7:0] oh, input logic er);
        vec_t t;
        t.rst = r; t.en = e; t.clr = c; t.vld = v; t.rdy = rd; t.mode = m; t.code = cd;
        t.w6 = w6; t.x_ir = ir; t.x_ov = ov; t.x_oh = oh; t.x_err = er;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drv(input logic r, input logic e, input logic c, input logic v,
                       input logic rd, input logic [1:0] m, input logic [2:0] cd);
        rst = r; en = e; clr = c; in_valid = v; out_ready = rd; mode = m; in_code = cd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        drv(1, 1, 0, 0, 1, 0, 0);

        // Reset and full sweep, LEVEL
        add(1,1,0,0,1,0,0,0, 0,0,8'h00,0);
        for (int i = 0; i < 8; i++) add(0,1,0,1,1,0,3'(i),0, 1,1,8'(1 << i),0);
        add(0,1,0,0,1,0,0,0, 1,0,8'h80,0);
        // Backpressure: code 2 refused while 5 is held, mode change does not re-decode
        add(0,1,0,1,0,0,5,0, 1,1,8'h20,0);
        add(0,1,0,1,0,0,2,0, 0,1,8'h20,0);
        add(0,1,0,1,0,1,2,0, 0,1,8'h20,0);
        add(0,1,0,1,1,0,2,0, 1,1,8'h04,0);
        add(0,1,0,0,1,0,0,0, 1,0,8'h04,0);
        // clr drops a held entry
        add(0,1,0,1,0,0,6,0, 1,1,8'h40,0);
        add(0,1,1,0,0,0,0,0, 0,0,8'h00,0);
        // Out of range / enable on OUT_W=6
        add(1,1,0,0,1,0,0,1, 0,0,8'h00,0);
        add(0,1,0,1,1,0,6,1, 1,1,8'h00,1);
        add(0,1,0,1,1,0,7,1, 1,1,8'h00,1);
        add(0,1,0,1,1,0,5,1, 1,1,8'h20,0);
        add(0,0,0,1,1,0,3,1, 1,1,8'h00,0);
        add(0,0,0,1,1,0,7,1, 1,1,8'h00,1);
        add(0,1,0,0,1,0,0,1, 1,0,8'h00,1);
        // PULSE
        add(1,1,0,0,1,0,0,0, 0,0,8'h00,0);
        add(0,1,0,1,1,1,4,0, 1,1,8'h10,0);
        add(0,1,0,0,1,1,0,0, 1,0,8'h00,0);
        add(0,1,0,1,0,1,3,0, 1,1,8'h08,0);
        add(0,1,0,0,0,1,0,0, 0,1,8'h08,0);
        add(0,1,0,0,1,1,0,0, 1,0,8'h00,0);
        add(0,1,0,1,1,1,1,0, 1,1,8'h02,0);
        add(0,1,0,1,1,0,2,0, 1,1,8'h04,0);
        add(0,1,0,0,1,0,0,0, 1,0,8'h04,0);
        // ACCUM and clr
        add(1,1,0,0,1,0,0,0, 0,0,8'h00,0);
        add(0,1,0,1,1,2,1,0, 1,1,8'h02,0);
        add(0,1,0,1,1,2,3,0, 1,1,8'h0A,0);
        add(0,1,0,1,1,2,6,0, 1,1,8'h4A,0);
        add(0,1,1,1,1,2,0,0, 1,0,8'h00,0);
        add(0,1,0,1,1,2,2,0, 1,1,8'h04,0);
        add(0,1,0,1,1,0,5,0, 1,1,8'h20,0);
        add(0,1,0,1,1,2,0,0, 1,1,8'h05,0);
        add(0,1,0,1,1,3,1,0, 1,1,8'h02,0);
        add(0,1,0,1,1,2,3,0, 1,1,8'h0D,0);
        add(0,0,0,1,1,2,7,0, 1,1,8'h0D,0);
        add(0,1,0,0,1,2,0,0, 1,0,8'h0D,0);
        // Reset mid-operation drops handshakes and the mask
        add(0,1,0,1,0,0,2,0, 1,1,8'h04,0);
        add(1,1,0,1,0,0,3,0, 0,0,8'h00,0);
        add(0,1,0,1,1,2,1,0, 1,1,8'h02,0);
        add(1,1,0,1,1,0,4,0, 0,0,8'h00,0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drv(v.rst, v.en, v.clr, v.vld, v.rdy, v.mode, v.code);
            #1;
            chk("in_ready", i, {15'd0, v.w6 ? in_ready6 : in_ready8}, {15'd0, v.x_ir});
            tick();
            chk("out_valid", i, {15'd0, v.w6 ? out_valid6 : out_valid8}, {15'd0, v.x_ov});
            chk("out_onehot", i, {8'd0, v.w6 ? {2'b00, out_onehot6} : out_onehot8}, {8'd0, v.x_oh});
            chk("out_err", i, {15'd0, v.w6 ? out_err6 : out_err8}, {15'd0, v.x_err});
        end

        // Held output stays stable under stall while inputs churn
        drv(1, 1, 0, 0, 1, 0, 0); tick();
        drv(0, 1, 0, 1, 0, 0, 5); tick();
        for (int k = 0; k < 6; k++) begin
            drv(0, k[0], k[1], 1, 0, 2'(k), 3'(k + 1));
            if (k[1]) clr = 1'b0;
            #1;
            chk("stall_in_ready", k, {15'd0, in_ready8}, 16'd0);
            tick();
            chk("stall_onehot", k, {8'd0, out_onehot8}, 16'h0020);
            chk("stall_valid", k, {15'd0, out_valid8}, 16'd1);
        end

`ifdef DECN_REG_HITCNT_EN
        drv(1, 1, 0, 0, 1, 0, 0); tick();
        chk("hit_reset", 0, hit_cnt6, 16'd0);
        drv(0, 1, 0, 1, 1, 0, 1); tick();
        drv(0, 0, 0, 1, 1, 0, 2); tick();
        drv(0, 1, 0, 1, 1, 2, 3); tick();
        drv(0, 1, 0, 1, 1, 0, 6); tick();
        drv(0, 1, 0, 0, 1, 0, 0); tick();
        chk("hit_cnt6", 1, hit_cnt6, 16'd3);
        chk("hit_cnt8", 1, hit_cnt8, 16'd4);
        drv(0, 1, 0, 1, 0, 0, 1); tick();
        chk("hit_loaded", 2, {15'd0, out_valid6}, 16'd1);
        drv(1, 1, 0, 1, 0, 0, 2); tick();
        chk("hit_rst_valid", 3, {15'd0, out_valid6}, 16'd0);
        chk("hit_rst_onehot", 3, {10'd0, out_onehot6}, 16'd0);
        chk("hit_rst_cnt", 3, hit_cnt6, 16'd0);
        drv(0, 1, 0, 1, 1, 0, 0); tick();
        drv(0, 1, 0, 1, 1, 0, 4); tick();
        chk("hit_recount", 4, hit_cnt6, 16'd2);
        drv(0, 1, 1, 1, 1, 0, 2); tick();
        chk("hit_clr", 5, hit_cnt6, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
